lcd_cmd_sequencer: RTL and testbench

Command front-end for the LCD image controller. A host pushes 4-bit LCD commands into a small FIFO; the sequencer pops them in order, filters illegal codes and issues each one to the controller on `cmd`/`cmd_valid`, pacing issue with the controller's `busy` output. After a WRITE (code 0) it waits for the controller's `done` before accepting the next command.

---
 rtl/lcd_cmd_sequencer.sv | 113 +++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_cmd_sequencer.sv
// Host command FIFO feeding the LCD controller: drops illegal codes, issues one command
// at a time on cmd/cmd_valid, paced by busy (after a guard gap) and by done after a WRITE.
module lcd_cmd_sequencer #(
   parameter int DEPTH = 16,
   parameter int GAP   = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [3:0]             host_cmd,
   input  logic                   host_push,
   output logic                   host_full,
   output logic [$clog2(DEPTH):0] fifo_count,
   output logic [3:0]             cmd,
   output logic                   cmd_valid,
   input  logic                   busy,
   input  logic                   done,
   output logic [7:0]             issued_cnt,
   output logic [3:0]             drop_cnt,
   output logic                   write_done,
   output logic                   seq_idle
);
   localparam int AW = $clog2(DEPTH);
   localparam int GW = $clog2(GAP + 1);

   typedef enum logic [2:0] {IDLE, ISSUE, HOLD, WAITB, WAITD} state_t;
   state_t state, state_nxt;

   logic [3:0]    mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   count;
   logic [GW-1:0] gap_cnt;
   logic [3:0]    head;
   logic          empty, push_ok, pop, head_legal, drop_inc;

   assign empty      = (count == '0);
   assign host_full  = (count == (AW+1)'(DEPTH));
   assign fifo_count = count;
   assign push_ok    = host_push && !host_full;
   assign head       = mem[rd_ptr];
   assign head_legal = (head < 4'd12);
   assign cmd_valid  = (state == ISSUE);
   assign seq_idle   = (state == IDLE) && empty;

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      drop_inc  = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && !busy) begin
               pop = 1'b1;
               if (head_legal) state_nxt = ISSUE;
               else            drop_inc  = 1'b1;
            end
         end
         ISSUE: state_nxt = HOLD;
         // busy is not trusted until the controller has had GAP cycles to raise it
         HOLD: begin
            if (gap_cnt == GW'(1)) state_nxt = WAITB;
         end
         WAITB: begin
            if (!busy) state_nxt = (cmd == 4'd0) ? WAITD : IDLE;
         end
         WAITD: begin
            if (done) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= host_cmd;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop)     rd_ptr <= rd_ptr + AW'(1);
         if (push_ok && !pop)      count <= count + (AW+1)'(1);
         else if (!push_ok && pop) count <= count - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cmd        <= 4'd0;
         issued_cnt <= 8'd0;
         drop_cnt   <= 4'd0;
         gap_cnt    <= '0;
         write_done <= 1'b0;
      end else begin
         write_done <= (state == WAITD) && done;
         if (pop && head_legal) cmd <= head;
         if (state == ISSUE) begin
            issued_cnt <= issued_cnt + 8'd1;
            gap_cnt    <= GW'(GAP);
         end else if (state == HOLD) begin
            gap_cnt <= gap_cnt - GW'(1);
         end
         if (drop_inc && drop_cnt != 4'hF) drop_cnt <= drop_cnt + 4'd1;
      end
   end

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Scenario bench for lcd_cmd_sequencer with a queue-based reference of what must be issued.
module tb_lcd_cmd_sequencer;
   localparam int DEPTH = 16;
   localparam int GAP   = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] host_cmd = 4'd0;
   logic       host_push = 1'b0;
   logic       host_full;
   logic [4:0] fifo_count;
   logic [3:0] cmd;
   logic       cmd_valid;
   logic       busy = 1'b0;
   logic       done = 1'b0;
   logic [7:0] issued_cnt;
   logic [3:0] drop_cnt;
   logic       write_done;
   logic       seq_idle;

   lcd_cmd_sequencer #(.DEPTH(DEPTH), .GAP(GAP)) dut (
      .clk(clk), .reset(reset), .host_cmd(host_cmd), .host_push(host_push),
      .host_full(host_full), .fifo_count(fifo_count), .cmd(cmd), .cmd_valid(cmd_valid),
      .busy(busy), .done(done), .issued_cnt(issued_cnt), .drop_cnt(drop_cnt),
      .write_done(write_done), .seq_idle(seq_idle)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int m_legal = 0;
   int m_illegal = 0;

   logic [3:0] obs_cmd[$];
   int         obs_t[$];
   int         wd_cnt = 0;
   int         wd_t = 0;

   always @(negedge clk) begin
      if (!reset) begin
         if (cmd_valid) begin
            obs_cmd.push_back(cmd);
            obs_t.push_back(cyc);
            checks++;
            if (cmd > 4'd11) begin
               errors++;
               $display("FAIL illegal_issue got %0d required 0..11", cmd);
            end
         end
         if (write_done) begin
            wd_cnt++;
            wd_t = cyc;
         end
      end
   end

   function automatic logic [7:0] exp_issued();
      return 8'(m_legal % 256);
   endfunction

   function automatic logic [3:0] exp_drop();
      return (m_illegal > 15) ? 4'd15 : 4'(m_illegal);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      obs_cmd.delete();
      obs_t.delete();
      wd_cnt = 0;
   endtask

   task automatic push(input logic [3:0] c, input bit accepted);
      host_cmd  = c;
      host_push = 1'b1;
      tick();
      host_push = 1'b0;
      if (accepted) begin
         if (c < 4'd12) m_legal++;
         else           m_illegal++;
      end
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n;
      n = 0;
      while (!seq_idle && n < budget) begin
         tick();
         n++;
      end
      tick();
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL %s timeout after %0d cycles, seq_idle=%0d required 1", name, n, seq_idle);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) tick();
      checks += 8;
      if (cmd !== 4'd0)        begin errors++; $display("FAIL rst_cmd got %0d expected 0", cmd); end
      if (cmd_valid !== 1'b0)  begin errors++; $display("FAIL rst_cmd_valid got %0d expected 0", cmd_valid); end
      if (issued_cnt !== 8'd0) begin errors++; $display("FAIL rst_issued got %0d expected 0", issued_cnt); end
      if (drop_cnt !== 4'd0)   begin errors++; $display("FAIL rst_drop got %0d expected 0", drop_cnt); end
      if (write_done !== 1'b0) begin errors++; $display("FAIL rst_write_done got %0d expected 0", write_done); end
      if (host_full !== 1'b0)  begin errors++; $display("FAIL rst_full got %0d expected 0", host_full); end
      if (fifo_count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d expected 0", fifo_count); end
      if (seq_idle !== 1'b1)   begin errors++; $display("FAIL rst_idle got %0d expected 1", seq_idle); end
      reset = 1'b0;
      m_legal = 0;
      m_illegal = 0;
      tick();
   endtask

   task automatic test_plain_issue();
      int t0;
      clear_obs();
      busy = 1'b0;
      done = 1'b0;
      t0 = cyc;
      push(4'd1, 1'b1);
      push(4'd2, 1'b1);
      push(4'd3, 1'b1);
      wait_idle(60, "plain_idle");
      checks++;
      if (obs_cmd.size() != 3) begin
         errors++;
         $display("FAIL plain_count got %0d expected 3", obs_cmd.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs_cmd[i] !== 4'(i + 1)) begin
               errors++;
               $display("FAIL plain_cmd[%0d] got %0d expected %0d", i, obs_cmd[i], i + 1);
            end
         end
         checks++;
         if (obs_t[0] - t0 != 2) begin
            errors++;
            $display("FAIL plain_latency got %0d expected 2", obs_t[0] - t0);
         end
         for (int i = 1; i < 3; i++) begin
            checks++;
            if (obs_t[i] - obs_t[i-1] != GAP + 3) begin
               errors++;
               $display("FAIL plain_spacing[%0d] got %0d expected %0d", i, obs_t[i] - obs_t[i-1], GAP + 3);
            end
         end
      end
      checks += 2;
      if (issued_cnt !== exp_issued()) begin errors++; $display("FAIL plain_issued got %0d expected %0d", issued_cnt, exp_issued()); end
      if (seq_idle !== 1'b1) begin errors++; $display("FAIL plain_idle got %0d expected 1", seq_idle); end
   endtask

   task automatic test_illegal();
      clear_obs();
      push(4'd13, 1'b1);
      push(4'd15, 1'b1);
      push(4'd5, 1'b1);
      wait_idle(60, "illegal_idle");
      checks += 3;
      if (drop_cnt !== exp_drop()) begin errors++; $display("FAIL illegal_drop got %0d expected %0d", drop_cnt, exp_drop()); end
      if (issued_cnt !== exp_issued()) begin errors++; $display("FAIL illegal_issued got %0d expected %0d", issued_cnt, exp_issued()); end
      if (obs_cmd.size() != 1 || obs_cmd[0] !== 4'd5) begin
         errors++;
         $display("FAIL illegal_seq got %0d issues (first %0d) expected one issue of 5", obs_cmd.size(), obs_cmd.size() ? obs_cmd[0] : 4'd0);
      end
   endtask

   task automatic test_busy_stall();
      int t0;
      clear_obs();
      busy = 1'b1;
      push(4'd7, 1'b1);
      repeat (8) tick();
      checks += 3;
      if (obs_cmd.size() != 0) begin errors++; $display("FAIL stall_no_issue got %0d issues expected 0", obs_cmd.size()); end
      if (fifo_count !== 5'd1) begin errors++; $display("FAIL stall_count got %0d expected 1", fifo_count); end
      if (cmd !== 4'd5) begin errors++; $display("FAIL stall_cmd_hold got %0d expected 5", cmd); end
      busy = 1'b0;
      t0 = cyc;
      wait_idle(40, "stall_idle");
      checks++;
      if (obs_cmd.size() != 1) begin
         errors++;
         $display("FAIL stall_issue_count got %0d expected 1", obs_cmd.size());
      end else begin
         checks += 2;
         if (obs_cmd[0] !== 4'd7) begin errors++; $display("FAIL stall_cmd got %0d expected 7", obs_cmd[0]); end
         // measured from the last cycle busy was high
         if (obs_t[0] - (t0 - 1) != 2) begin errors++; $display("FAIL stall_latency got %0d expected 2", obs_t[0] - (t0 - 1)); end
      end
   endtask

   task automatic test_write();
      int n;
      clear_obs();
      busy = 1'b0;
      done = 1'b0;
      push(4'd0, 1'b1);
      push(4'd4, 1'b1);
      n = 0;
      while (obs_cmd.size() == 0 && n < 20) begin tick(); n++; end
      checks++;
      if (n >= 20) begin errors++; $display("FAIL write_issue timeout got 0 issues expected 1"); end
      busy = 1'b1;
      repeat (10) tick();
      busy = 1'b0;
      repeat (3) tick();
      checks++;
      if (obs_cmd.size() != 1) begin errors++; $display("FAIL write_wait_done got %0d issues expected 1", obs_cmd.size()); end
      done = 1'b1;
      n = 0;
      while (wd_cnt == 0 && n < 20) begin tick(); n++; end
      done = 1'b0;
      wait_idle(40, "write_idle");
      checks += 3;
      if (wd_cnt != 1) begin errors++; $display("FAIL write_done_pulses got %0d expected 1", wd_cnt); end
      if (obs_cmd.size() != 2 || obs_cmd[0] !== 4'd0 || obs_cmd[1] !== 4'd4) begin
         errors++;
         $display("FAIL write_seq got %0d issues expected 0 then 4", obs_cmd.size());
      end else if (obs_t[1] <= wd_t) begin
         errors++;
         $display("FAIL write_order got issue at %0d expected after write_done at %0d", obs_t[1], wd_t);
      end
      if (cmd !== 4'd4) begin errors++; $display("FAIL write_cmd_hold got %0d expected 4", cmd); end
   endtask

   task automatic test_fifo_full();
      logic [3:0] exp[$];
      logic [3:0] c;
      clear_obs();
      busy = 1'b1;
      done = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) begin
         c = 4'($urandom_range(0, 11));
         push(c, i < DEPTH);
         if (i < DEPTH) exp.push_back(c);
      end
      checks += 2;
      if (host_full !== 1'b1) begin errors++; $display("FAIL full_flag got %0d expected 1", host_full); end
      if (fifo_count !== 5'(DEPTH)) begin errors++; $display("FAIL full_count got %0d expected %0d", fifo_count, DEPTH); end
      busy = 1'b0;
      wait_idle(300, "full_idle");
      done = 1'b0;
      checks++;
      if (obs_cmd.size() != DEPTH) begin
         errors++;
         $display("FAIL full_issues got %0d expected %0d", obs_cmd.size(), DEPTH);
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (obs_cmd[i] !== exp[i]) begin errors++; $display("FAIL full_order[%0d] got %0d expected %0d", i, obs_cmd[i], exp[i]); end
         end
      end
      checks++;
      if (issued_cnt !== exp_issued()) begin errors++; $display("FAIL full_issued got %0d expected %0d", issued_cnt, exp_issued()); end
   endtask

   task automatic test_collision_reset();
      int n;
      clear_obs();
      busy = 1'b0;
      done = 1'b0;
      host_cmd = 4'd5; host_push = 1'b1;
      tick();
      checks++;
      if (fifo_count !== 5'd1) begin errors++; $display("FAIL coll_first got %0d expected 1", fifo_count); end
      host_cmd = 4'd9;
      tick();
      checks += 2;
      if (fifo_count !== 5'd1) begin errors++; $display("FAIL coll_count got %0d expected 1", fifo_count); end
      if (cmd_valid !== 1'b1 || cmd !== 4'd5) begin errors++; $display("FAIL coll_issue got valid=%0d cmd=%0d expected valid=1 cmd=5", cmd_valid, cmd); end
      host_cmd = 4'd2;
      tick();
      host_push = 1'b0;
      checks++;
      if (fifo_count !== 5'd2) begin errors++; $display("FAIL coll_count2 got %0d expected 2", fifo_count); end
      reset = 1'b1;
      #1;
      checks += 4;
      if (cmd_valid !== 1'b0)  begin errors++; $display("FAIL hold_rst_valid got %0d expected 0", cmd_valid); end
      if (fifo_count !== 5'd0) begin errors++; $display("FAIL hold_rst_count got %0d expected 0", fifo_count); end
      if (seq_idle !== 1'b1)   begin errors++; $display("FAIL hold_rst_idle got %0d expected 1", seq_idle); end
      if (issued_cnt !== 8'd0) begin errors++; $display("FAIL hold_rst_issued got %0d expected 0", issued_cnt); end
      tick();
      reset = 1'b0;
      m_legal = 0;
      m_illegal = 0;
      tick();
      push(4'd3, 1'b0);
      n = 0;
      while (cmd_valid !== 1'b1 && n < 10) begin tick(); n++; end
      checks++;
      if (n >= 10) begin errors++; $display("FAIL inflight_issue timeout got valid=0 expected 1"); end
      reset = 1'b1;
      #1;
      checks++;
      if (cmd_valid !== 1'b0) begin errors++; $display("FAIL inflight_rst_valid got %0d expected 0", cmd_valid); end
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_random();
      logic [3:0] exp[$];
      logic [3:0] c;
      int n, nwr, k;
      for (int b = 0; b < 6; b++) begin
         clear_obs();
         exp.delete();
         nwr = 0;
         n = $urandom_range(8, DEPTH);
         for (int i = 0; i < n; i++) begin
            busy = ($urandom_range(0, 3) == 0);
            done = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) tick();
            c = 4'($urandom_range(0, 15));
            push(c, 1'b1);
            if (c < 4'd12) exp.push_back(c);
            if (c == 4'd0) nwr++;
         end
         k = 0;
         while (!seq_idle && k < 400) begin
            busy = ($urandom_range(0, 3) == 0);
            done = 1'($urandom_range(0, 1));
            tick();
            k++;
         end
         busy = 1'b0;
         done = 1'b0;
         tick();
         checks += 4;
         if (k >= 400) begin errors++; $display("FAIL rnd%0d_timeout got seq_idle=%0d expected 1", b, seq_idle); end
         if (wd_cnt != nwr) begin errors++; $display("FAIL rnd%0d_writes got %0d expected %0d", b, wd_cnt, nwr); end
         if (issued_cnt !== exp_issued()) begin errors++; $display("FAIL rnd%0d_issued got %0d expected %0d", b, issued_cnt, exp_issued()); end
         if (drop_cnt !== exp_drop()) begin errors++; $display("FAIL rnd%0d_drop got %0d expected %0d", b, drop_cnt, exp_drop()); end
         checks++;
         if (obs_cmd.size() != exp.size()) begin
            errors++;
            $display("FAIL rnd%0d_count got %0d expected %0d", b, obs_cmd.size(), exp.size());
         end else begin
            for (int i = 0; i < exp.size(); i++) begin
               checks++;
               if (obs_cmd[i] !== exp[i]) begin errors++; $display("FAIL rnd%0d_order[%0d] got %0d expected %0d", b, i, obs_cmd[i], exp[i]); end
               if (i > 0) begin
                  checks++;
                  if (obs_t[i] - obs_t[i-1] < GAP + 3) begin
                     errors++;
                     $display("FAIL rnd%0d_spacing[%0d] got %0d expected >= %0d", b, i, obs_t[i] - obs_t[i-1], GAP + 3);
                  end
               end
            end
         end
      end
   endtask

   task automatic test_drop_saturation();
      logic [7:0] issued_before;
      clear_obs();
      issued_before = exp_issued();
      for (int i = 0; i < DEPTH; i++) push(4'($urandom_range(12, 15)), 1'b1);
      wait_idle(100, "sat_idle");
      checks += 3;
      if (drop_cnt !== 4'd15) begin errors++; $display("FAIL sat_drop got %0d expected 15", drop_cnt); end
      if (issued_cnt !== issued_before) begin errors++; $display("FAIL sat_issued got %0d expected %0d", issued_cnt, issued_before); end
      if (obs_cmd.size() != 0) begin errors++; $display("FAIL sat_no_issue got %0d expected 0", obs_cmd.size()); end
   endtask

   initial begin
      test_reset();
      test_plain_issue();
      test_illegal();
      test_busy_stall();
      test_write();
      test_fifo_full();
      test_collision_reset();
      test_random();
      test_drop_saturation();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
